// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory line arbiter.
package arb_types;

    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging the icache and dcache line-miss ports onto one
// line-wide physical memory port. One transaction is in flight at a time;
// address, op and write data are latched at grant so that requester changes
// during service have no effect on the memory side.
module mem_arbiter
    import arb_types::arb_state_e;
    import arb_types::IDLE;
    import arb_types::SERVE_I;
    import arb_types::SERVE_D;
    import arb_types::DONE;
    import arb_types::OFFSET_BITS;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    // Clears the within-line offset bits of a requester address.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

    arb_state_e        state_q, state_d;
    logic              last_grant_q;   // 0 = I owned last, 1 = D owned last
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic i_req, d_req, grant_i, grant_d, serving;

    // Request decode and round-robin tie-break (only acts in IDLE).
    always_comb begin
        i_req   = i_read;
        d_req   = d_read | d_write;
        grant_d = (state_q == IDLE) && d_req && (!i_req || !last_grant_q);
        grant_i = (state_q == IDLE) && i_req && (!d_req ||  last_grant_q);
    end

    // State register plus transaction latches captured at grant time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (grant_i) begin
                addr_q       <= i_addr & ALIGN_MASK;
                op_write_q   <= 1'b0;
                last_grant_q <= 1'b0;
            end else if (grant_d) begin
                addr_q       <= d_addr & ALIGN_MASK;
                op_write_q   <= d_write;   // write wins over a simultaneous read
                wdata_q      <= d_wdata;
                last_grant_q <= 1'b1;
            end
        end
    end

    // Next-state logic; DONE is a mandatory one-cycle gap after each response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_i)      state_d = SERVE_I;
                else if (grant_d) state_d = SERVE_D;
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side strobes and requester responses, qualified by the owner.
    always_comb begin
        serving    = (state_q == SERVE_I) || (state_q == SERVE_D);
        pmem_read  = serving && !op_write_q;
        pmem_write = serving &&  op_write_q;
        pmem_addr  = addr_q;
        pmem_wdata = wdata_q;
        i_rdata    = pmem_rdata;
        d_rdata    = pmem_rdata;
        i_resp     = (state_q == SERVE_I) && pmem_resp;
        d_resp     = (state_q == SERVE_D) && pmem_resp;
    end

endmodule
